// File: rtl/exc_commit_ctrl_pkg.sv
// Shared constants and types for the exception/ertn commit sequencer.
//  - ECODE_* / ESUBCODE_* : exception codes handed to the CSR file
//  - WB_CAUSE_*           : bit positions inside the WB cause vector
//  - exc_state_e          : sequencer states
//  - exc_dec_t            : result of cause prioritisation
package exc_commit_ctrl_pkg;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0B;
  localparam logic [5:0] ECODE_BRK = 6'h0C;
  localparam logic [5:0] ECODE_INE = 6'h0D;
  localparam logic [5:0] ECODE_IPE = 6'h0E;

  localparam logic [8:0] ESUBCODE_ADEF = 9'd0;
  localparam logic [8:0] ESUBCODE_ADEM = 9'd1;

  localparam int WB_CAUSE_W    = 7;
  localparam int WB_CAUSE_RSVD = 0;
  localparam int WB_CAUSE_ADEF = 1;
  localparam int WB_CAUSE_INE  = 2;
  localparam int WB_CAUSE_SYS  = 3;
  localparam int WB_CAUSE_BRK  = 4;
  localparam int WB_CAUSE_ALE  = 5;
  localparam int WB_CAUSE_ADEM = 6;

  typedef enum logic [1:0] {
    EXC_ST_IDLE     = 2'd0,
    EXC_ST_TRAP     = 2'd1,
    EXC_ST_REDIRECT = 2'd2
  } exc_state_e;

  typedef struct packed {
    logic       take;
    logic [5:0] ecode;
    logic [8:0] esubcode;
  } exc_dec_t;

endpackage

// File: rtl/exc_commit_ctrl_if.sv
// Bundle of WB-side, CSR-side and fetch-redirect signals of the commit sequencer.
//  master : the sequencer (drives wb_ready, CSR strobes/latches, flush, redirect, trap_cnt)
//  slave  : pipeline + CSR file + IF (drive WB instruction info, PLV/interrupt, ex_entry,
//           redirect_ready)
interface exc_commit_ctrl_if
  import exc_commit_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic                  wb_valid;
  logic                  wb_ready;
  logic [31:0]           wb_pc;
  logic [31:0]           wb_vaddr;
  logic [WB_CAUSE_W-1:0] wb_cause;
  logic                  wb_is_ertn;
  logic                  wb_is_priv;
  logic [1:0]            csr_plv;
  logic                  has_int;
  logic [31:0]           ex_entry;
  logic                  csr_wb_ex;
  logic                  csr_ertn_flush;
  logic [31:0]           csr_pc;
  logic [31:0]           csr_vaddr;
  logic [5:0]            csr_ecode;
  logic [8:0]            csr_esubcode;
  logic                  flush;
  logic                  redirect_valid;
  logic                  redirect_ready;
  logic [31:0]           redirect_pc;
  logic [CNT_W-1:0]      trap_cnt;

  modport master (
    input  wb_valid, wb_pc, wb_vaddr, wb_cause, wb_is_ertn, wb_is_priv,
    input  csr_plv, has_int, ex_entry, redirect_ready,
    output wb_ready, csr_wb_ex, csr_ertn_flush, csr_pc, csr_vaddr, csr_ecode,
    output csr_esubcode, flush, redirect_valid, redirect_pc, trap_cnt
  );

  modport slave (
    output wb_valid, wb_pc, wb_vaddr, wb_cause, wb_is_ertn, wb_is_priv,
    output csr_plv, has_int, ex_entry, redirect_ready,
    input  wb_ready, csr_wb_ex, csr_ertn_flush, csr_pc, csr_vaddr, csr_ecode,
    input  csr_esubcode, flush, redirect_valid, redirect_pc, trap_cnt
  );
endinterface

// File: rtl/exc_commit_ctrl_prio_enc.sv
// exc_prio_enc: combinational exception prioritiser.
//  cause   in  WB cause flags (WB_CAUSE_* positions)
//  has_int in  pending enabled interrupt
//  ipe     in  privileged instruction executed at PLV != 0
//  dec     out {take, ecode, esubcode} of the highest-priority event; all zero when none
// The reserved cause bit carries no exception code and is not decoded.
module exc_prio_enc
  import exc_commit_ctrl_pkg::*;
(
  input  logic [WB_CAUSE_W-1:0] cause,
  input  logic                  has_int,
  input  logic                  ipe,
  output exc_dec_t              dec
);

  always_comb begin
    dec      = '0;
    dec.take = 1'b1;
    if (has_int)                    dec.ecode = ECODE_INT;
    else if (cause[WB_CAUSE_ADEF])  begin
      dec.ecode    = ECODE_ADE;
      dec.esubcode = ESUBCODE_ADEF;
    end
    else if (cause[WB_CAUSE_INE])   dec.ecode = ECODE_INE;
    else if (ipe)                   dec.ecode = ECODE_IPE;
    else if (cause[WB_CAUSE_SYS])   dec.ecode = ECODE_SYS;
    else if (cause[WB_CAUSE_BRK])   dec.ecode = ECODE_BRK;
    else if (cause[WB_CAUSE_ALE])   dec.ecode = ECODE_ALE;
    else if (cause[WB_CAUSE_ADEM])  begin
      dec.ecode    = ECODE_ADE;
      dec.esubcode = ESUBCODE_ADEM;
    end
    else                            dec.take  = 1'b0;
  end

endmodule

// File: rtl/exc_commit_ctrl.sv
// exc_commit_ctrl: exception/ertn commit sequencer between WB and the CSR file.
//  clk, reset : clock, asynchronous active-high reset
//  bus        : exc_commit_ctrl_if.master
//     WB in        wb_valid/wb_pc/wb_vaddr/wb_cause/wb_is_ertn/wb_is_priv, wb_ready out
//     CSR in       csr_plv, has_int, ex_entry
//     CSR out      csr_wb_ex, csr_ertn_flush (1-cycle strobes), csr_pc/vaddr/ecode/esubcode
//     pipeline out flush
//     IF           redirect_valid/redirect_pc out, redirect_ready in
//     stats out    trap_cnt (saturating count of exceptions + interrupts)
// Sequence: IDLE accepts a trapping instruction -> TRAP (one cycle, CSR strobe) ->
// REDIRECT (held until IF accepts) -> IDLE.
module exc_commit_ctrl
  import exc_commit_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               reset,
  exc_commit_ctrl_if.master bus
);

  exc_state_e       state;
  logic             wb_ready_q;
  logic             csr_wb_ex_q;
  logic             csr_ertn_flush_q;
  logic [31:0]      csr_pc_q;
  logic [31:0]      csr_vaddr_q;
  logic [5:0]       csr_ecode_q;
  logic [8:0]       csr_esubcode_q;
  logic             flush_q;
  logic             redirect_valid_q;
  logic [31:0]      redirect_pc_q;
  logic [CNT_W-1:0] trap_cnt_q;

  exc_dec_t dec;
  logic     ipe;
  logic     accept;
  logic     is_ertn;
  logic     adef_sel;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign ipe = bus.wb_is_priv & (bus.csr_plv != 2'd0);

  exc_prio_enc u_prio (
    .cause   (bus.wb_cause),
    .has_int (bus.has_int),
    .ipe     (ipe),
    .dec     (dec)
  );

  // Any exception or interrupt turns an ertn into an ordinary trap.
  assign is_ertn  = bus.wb_is_ertn & ~dec.take;
  assign accept   = wb_ready_q & bus.wb_valid & (dec.take | bus.wb_is_ertn);
  assign adef_sel = dec.take & (dec.ecode == ECODE_ADE) & (dec.esubcode == ESUBCODE_ADEF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= EXC_ST_IDLE;
      wb_ready_q       <= 1'b0;
      csr_wb_ex_q      <= 1'b0;
      csr_ertn_flush_q <= 1'b0;
      csr_pc_q         <= '0;
      csr_vaddr_q      <= '0;
      csr_ecode_q      <= '0;
      csr_esubcode_q   <= '0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      trap_cnt_q       <= '0;
    end else begin
      case (state)
        // IDLE: accept commit, latch trap context
        EXC_ST_IDLE: begin
          wb_ready_q <= 1'b1;
          if (accept) begin
            state            <= EXC_ST_TRAP;
            wb_ready_q       <= 1'b0;
            csr_wb_ex_q      <= 1'b1;
            csr_ertn_flush_q <= is_ertn;
            flush_q          <= 1'b1;
            csr_pc_q         <= bus.wb_pc;
            csr_vaddr_q      <= adef_sel ? bus.wb_pc : bus.wb_vaddr;
            csr_ecode_q      <= dec.ecode;
            csr_esubcode_q   <= dec.esubcode;
          end
        end
        // TRAP: CSR strobe cycle, ex_entry is valid from the CSR file now
        EXC_ST_TRAP: begin
          state            <= EXC_ST_REDIRECT;
          csr_wb_ex_q      <= 1'b0;
          csr_ertn_flush_q <= 1'b0;
          redirect_valid_q <= 1'b1;
          redirect_pc_q    <= bus.ex_entry;
          if (!csr_ertn_flush_q) trap_cnt_q <= sat_inc(trap_cnt_q);
        end
        // REDIRECT: hold target until IF takes it
        EXC_ST_REDIRECT: begin
          if (bus.redirect_ready) begin
            state            <= EXC_ST_IDLE;
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
            wb_ready_q       <= 1'b1;
          end
        end
        default: state <= EXC_ST_IDLE;
      endcase
    end
  end

  assign bus.wb_ready       = wb_ready_q;
  assign bus.csr_wb_ex      = csr_wb_ex_q;
  assign bus.csr_ertn_flush = csr_ertn_flush_q;
  assign bus.csr_pc         = csr_pc_q;
  assign bus.csr_vaddr      = csr_vaddr_q;
  assign bus.csr_ecode      = csr_ecode_q;
  assign bus.csr_esubcode   = csr_esubcode_q;
  assign bus.flush          = flush_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.trap_cnt       = trap_cnt_q;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Testbench for exc_commit_ctrl: directed scenarios followed by randomized commits,
// compared against a cause-priority table model. A second instance with a 2-bit
// counter shares all inputs to exercise counter saturation.
module tb_exc_commit_ctrl;

  logic clk;
  logic reset;

  exc_commit_ctrl_if #(.CNT_W(16)) bus  ();
  exc_commit_ctrl_if #(.CNT_W(2))  bus2 ();

  exc_commit_ctrl #(.CNT_W(16)) dut  (.clk(clk), .reset(reset), .bus(bus));
  exc_commit_ctrl #(.CNT_W(2))  dut2 (.clk(clk), .reset(reset), .bus(bus2));

  assign bus2.wb_valid       = bus.wb_valid;
  assign bus2.wb_pc          = bus.wb_pc;
  assign bus2.wb_vaddr       = bus.wb_vaddr;
  assign bus2.wb_cause       = bus.wb_cause;
  assign bus2.wb_is_ertn     = bus.wb_is_ertn;
  assign bus2.wb_is_priv     = bus.wb_is_priv;
  assign bus2.csr_plv        = bus.csr_plv;
  assign bus2.has_int        = bus.has_int;
  assign bus2.ex_entry       = bus.ex_entry;
  assign bus2.redirect_ready = bus.redirect_ready;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference state: what the CSR latches and counter must hold.
  int unsigned m_cnt   = 0;
  logic [31:0] m_pc    = '0;
  logic [31:0] m_vaddr = '0;
  logic [5:0]  m_ec    = '0;
  logic [8:0]  m_es    = '0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // Priority table, highest first: INT, ADEF, INE, IPE, SYS, BRK, ALE, ADEM.
  function automatic void ref_decode(input logic [6:0] c, input logic intr, input logic ipe,
                                     output logic take, output logic [5:0] ec,
                                     output logic [8:0] es);
    logic hit [8];
    int   code [8];
    int   sub  [8];
    code = '{0, 8, 13, 14, 11, 12, 9, 8};
    sub  = '{0, 0, 0, 0, 0, 0, 0, 1};
    hit  = '{intr, c[1], c[2], ipe, c[3], c[4], c[5], c[6]};
    take = 1'b0;
    ec   = '0;
    es   = '0;
    for (int k = 7; k >= 0; k--) begin
      if (hit[k]) begin
        take = 1'b1;
        ec   = 6'(code[k]);
        es   = 9'(sub[k]);
      end
    end
  endfunction

  function automatic logic [31:0] cnt_sat(input int unsigned n, input int unsigned maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One WB commit, starting and ending on a negedge with the DUT in IDLE.
  task automatic commit(input logic [31:0] pc, input logic [31:0] vaddr, input logic [6:0] cause,
                        input logic ertn, input logic priv, input logic [1:0] plv,
                        input logic intr, input logic [31:0] entry, input int rdy_dly);
    logic       take;
    logic       ipe;
    logic       trig;
    logic       m_ertn;
    logic [5:0] ec;
    logic [8:0] es;
    check_val("idle_wb_ready", bus.wb_ready, 1);
    bus.wb_valid   = 1'b1;
    bus.wb_pc      = pc;
    bus.wb_vaddr   = vaddr;
    bus.wb_cause   = cause;
    bus.wb_is_ertn = ertn;
    bus.wb_is_priv = priv;
    bus.csr_plv    = plv;
    bus.has_int    = intr;
    bus.ex_entry   = entry;
    ipe = priv && (plv != 2'd0);
    ref_decode(cause, intr, ipe, take, ec, es);
    trig   = take || ertn;
    m_ertn = ertn && !take;
    tick();
    bus.wb_valid = 1'b0;
    bus.has_int  = 1'($urandom);
    if (!trig) begin
      check_val("notrig_wb_ex", bus.csr_wb_ex, 0);
      check_val("notrig_flush", bus.flush, 0);
      check_val("notrig_ready", bus.wb_ready, 1);
      check_val("notrig_cnt", bus.trap_cnt, m_cnt);
      check_val("notrig_pc_hold", bus.csr_pc, m_pc);
      check_val("notrig_ec_hold", bus.csr_ecode, m_ec);
      return;
    end
    m_pc    = pc;
    m_vaddr = (take && ec == 6'h08 && es == 9'd0) ? pc : vaddr;
    m_ec    = ec;
    m_es    = es;
    check_val("trap_wb_ex", bus.csr_wb_ex, 1);
    check_val("trap_ertn_flush", bus.csr_ertn_flush, m_ertn);
    check_val("trap_flush", bus.flush, 1);
    check_val("trap_wb_ready", bus.wb_ready, 0);
    check_val("trap_rvalid", bus.redirect_valid, 0);
    check_val("trap_pc", bus.csr_pc, m_pc);
    check_val("trap_vaddr", bus.csr_vaddr, m_vaddr);
    check_val("trap_ecode", bus.csr_ecode, m_ec);
    check_val("trap_esub", bus.csr_esubcode, m_es);
    tick();
    bus.ex_entry = $urandom;
    if (!m_ertn) m_cnt++;
    check_val("rd_wb_ex", bus.csr_wb_ex, 0);
    check_val("rd_ertn_flush", bus.csr_ertn_flush, 0);
    check_val("rd_cnt", bus.trap_cnt, cnt_sat(m_cnt, 65535));
    check_val("rd_cnt2", bus2.trap_cnt, cnt_sat(m_cnt, 3));
    for (int i = 0; i <= rdy_dly; i++) begin
      bus.redirect_ready = (i == rdy_dly);
      check_val("rd_valid", bus.redirect_valid, 1);
      check_val("rd_pc", bus.redirect_pc, entry);
      check_val("rd_flush", bus.flush, 1);
      check_val("rd_wb_ready", bus.wb_ready, 0);
      tick();
    end
    bus.redirect_ready = 1'b0;
    check_val("post_valid", bus.redirect_valid, 0);
    check_val("post_flush", bus.flush, 0);
    check_val("post_wb_ready", bus.wb_ready, 1);
  endtask

  initial begin
    logic [6:0]  rc;
    logic        rint;
    logic        rertn;
    logic        rpriv;
    logic [1:0]  rplv;
    reset              = 1'b1;
    bus.wb_valid       = 1'b0;
    bus.wb_pc          = '0;
    bus.wb_vaddr       = '0;
    bus.wb_cause       = '0;
    bus.wb_is_ertn     = 1'b0;
    bus.wb_is_priv     = 1'b0;
    bus.csr_plv        = 2'd0;
    bus.has_int        = 1'b0;
    bus.ex_entry       = '0;
    bus.redirect_ready = 1'b0;
    #1;
    check_val("rst_wb_ready", bus.wb_ready, 0);
    check_val("rst_wb_ex", bus.csr_wb_ex, 0);
    check_val("rst_flush", bus.flush, 0);
    check_val("rst_rvalid", bus.redirect_valid, 0);
    check_val("rst_cnt", bus.trap_cnt, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Plain instruction, then SYS with a stalled redirect.
    commit(32'h1c000010, 32'h0, 7'h00, 0, 0, 2'd0, 0, 32'h0, 0);
    commit(32'h1c000020, 32'h0, 7'h08, 0, 0, 2'd0, 0, 32'h1c008000, 3);
    // INT beats ALE; ALE alone.
    commit(32'h1c000030, 32'h1002, 7'h20, 0, 0, 2'd0, 1, 32'h1c008000, 1);
    commit(32'h1c000034, 32'h1002, 7'h20, 0, 0, 2'd0, 0, 32'h1c008000, 0);
    // ertn at PLV0 and PLV3.
    commit(32'h1c000040, 32'h0, 7'h00, 1, 1, 2'd0, 0, 32'h1c000100, 0);
    commit(32'h1c000044, 32'h0, 7'h00, 1, 1, 2'd3, 0, 32'h1c008000, 0);
    // ADEM, ADEF, ADEF+INE.
    commit(32'h1c000050, 32'h2003, 7'h40, 0, 0, 2'd0, 0, 32'h1c008000, 0);
    commit(32'h1c000054, 32'h2003, 7'h02, 0, 0, 2'd0, 0, 32'h1c008000, 0);
    commit(32'h1c000058, 32'h2003, 7'h06, 0, 0, 2'd0, 0, 32'h1c008000, 2);

    // Asynchronous reset in the middle of REDIRECT.
    bus.wb_valid = 1'b1;
    bus.wb_cause = 7'h08;
    bus.ex_entry = 32'h1c008000;
    tick();
    bus.wb_valid = 1'b0;
    tick();
    check_val("mid_rvalid", bus.redirect_valid, 1);
    #2 reset = 1'b1;
    #1;
    check_val("arst_rvalid", bus.redirect_valid, 0);
    check_val("arst_flush", bus.flush, 0);
    check_val("arst_rpc", bus.redirect_pc, 0);
    check_val("arst_csr_pc", bus.csr_pc, 0);
    check_val("arst_cnt", bus.trap_cnt, 0);
    check_val("arst_wb_ready", bus.wb_ready, 0);
    bus.wb_cause = 7'h00;
    @(negedge clk);
    tick();
    reset = 1'b0;
    m_cnt = 0;
    m_pc = '0;
    m_vaddr = '0;
    m_ec = '0;
    m_es = '0;
    tick();
    check_val("rel_wb_ready", bus.wb_ready, 1);

    // Five traps: 2-bit counter must stick at 3.
    for (int i = 0; i < 5; i++)
      commit(32'h1c000060 + 32'(i * 4), 32'h0, 7'h10, 0, 0, 2'd0, 0, 32'h1c008000, 0);
    check_val("cnt2_sat", bus2.trap_cnt, 3);
    check_val("cnt16_five", bus.trap_cnt, 5);

    // Randomized commits (reserved cause bit kept clear).
    for (int n = 0; n < 150; n++) begin
      rc    = 7'($urandom) & 7'h7E;
      rint  = ($urandom_range(0, 7) == 0);
      rertn = ($urandom_range(0, 5) == 0);
      rpriv = 1'($urandom);
      rplv  = 2'($urandom);
      if ($urandom_range(0, 1) == 0) rc = rc & (7'h01 << $urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) begin
        rc    = '0;
        rint  = 1'b0;
        rertn = 1'b0;
        rplv  = 2'd0;
      end
      commit($urandom, $urandom, rc, rertn, rpriv, rplv, rint, $urandom,
             int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
